regset_arb: RTL

REGSET_ARB -- requirements
Module: regset_arb

---
 rtl/regset_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/regset_arb.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regset_pkg.sv
// Shared types for the regset arbiter: op encoding, FSM states, counter width.
// The SWAP states only exist when REGSET_ARB_SWAP_EN is defined.
package regset_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_SWAP = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_TURN   = 3'd3
`ifdef REGSET_ARB_SWAP_EN
    ,
    ST_SWAP_A = 3'd4,
    ST_SWAP_B = 3'd5,
    ST_SWAP_C = 3'd6
`endif
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester whenever a grant is accepted.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_nReset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic prio1;  // 1: requester 1 wins a tie

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) grant = prio1 ? 2'b10 : 2'b01;
    else              grant = req;
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      prio1 <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio1 <= grant[0];
    end
  end

endmodule

// File: rtl/regset_arb.sv
// Two-requester arbiter in front of a two-register regset with a shared read bus.
// Optional SWAP op is compiled in with REGSET_ARB_SWAP_EN.
module regset_arb
  import regset_pkg::*;
#(
  parameter int DRIVE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_nReset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_op0,
  input  logic [1:0] i_op1,
  input  logic       i_sel0,
  input  logic       i_sel1,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic [7:0] i_bus,
  output logic [1:0] o_ack,
  output logic       o_err,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic [7:0] o_d,
  output logic       o_write0,
  output logic       o_write1,
  output logic       o_busSel,
  output logic       o_nBusEn,
  output logic [2:0] o_state
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur;       // one-hot owner of the op in flight
  logic [1:0]       ack_mask;  // requester acked last cycle, ignored for one IDLE cycle
  logic [1:0]       req_eff;
  logic [1:0]       grant;
  logic             accept;
  op_e              gop;
  logic             gsel;
  logic [7:0]       gdata;
`ifdef REGSET_ARB_SWAP_EN
  logic [7:0]       tmp;
  logic             swap_last;
`endif

  assign req_eff = (state == ST_IDLE) ? (i_req & ~ack_mask) : 2'b00;
  assign accept  = (state == ST_IDLE) && (grant != 2'b00);
  assign gop     = op_e'(grant[1] ? i_op1 : i_op0);
  assign gsel    = grant[1] ? i_sel1 : i_sel0;
  assign gdata   = grant[1] ? i_data1 : i_data0;
  assign o_state = state;

  rr_arb2 u_rr (
    .i_clk    (i_clk),
    .i_nReset (i_nReset),
    .req      (req_eff),
    .accept   (accept),
    .grant    (grant)
  );

  // Every output is a flop: a state's outputs are loaded on the edge entering it.
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur       <= 2'b00;
      ack_mask  <= 2'b00;
      o_ack     <= 2'b00;
      o_err     <= 1'b0;
      o_rdata   <= 8'h00;
      o_busy    <= 1'b0;
      o_d       <= 8'h00;
      o_write0  <= 1'b0;
      o_write1  <= 1'b0;
      o_busSel  <= 1'b0;
      o_nBusEn  <= 1'b1;
`ifdef REGSET_ARB_SWAP_EN
      tmp       <= 8'h00;
      swap_last <= 1'b0;
`endif
    end else begin
      ack_mask <= o_ack;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cur    <= grant;
            cnt    <= CNT_W'(DRIVE_CYCLES - 1);
            o_busy <= 1'b1;
            case (gop)
              OP_WR: begin
                state    <= ST_WRITE;
                o_d      <= gdata;
                o_write0 <= ~gsel;
                o_write1 <= gsel;
                o_ack    <= grant;
              end
              OP_RD: begin
                state    <= ST_DRIVE;
                o_nBusEn <= 1'b0;
                o_busSel <= gsel;
              end
`ifdef REGSET_ARB_SWAP_EN
              OP_SWAP: begin
                state     <= ST_SWAP_A;
                o_nBusEn  <= 1'b0;
                o_busSel  <= 1'b0;
                swap_last <= 1'b0;
              end
`endif
              default: begin
                // rejected op: acknowledge with error, touch neither regs nor bus
                state <= ST_TURN;
                o_ack <= grant;
                o_err <= 1'b1;
              end
            endcase
          end
        end
        ST_DRIVE: begin
          if (cnt == '0) begin
            state    <= ST_TURN;
            o_nBusEn <= 1'b1;
            o_rdata  <= i_bus;
            o_ack    <= cur;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef REGSET_ARB_SWAP_EN
        ST_SWAP_A: begin
          state    <= ST_SWAP_B;
          tmp      <= i_bus;
          o_busSel <= 1'b1;
        end
        ST_SWAP_B: begin
          state    <= ST_SWAP_C;
          o_d      <= i_bus;
          o_write0 <= 1'b1;
          o_nBusEn <= 1'b1;
        end
        ST_SWAP_C: begin
          // r_1 write trails the r_0 write by a cycle so the strobes never overlap
          if (!swap_last) begin
            swap_last <= 1'b1;
            o_write0  <= 1'b0;
            o_write1  <= 1'b1;
            o_d       <= tmp;
            o_ack     <= cur;
          end else begin
            state    <= ST_IDLE;
            o_write1 <= 1'b0;
            o_ack    <= 2'b00;
            o_busy   <= 1'b0;
          end
        end
`endif
        default: begin
          // WRITE and TURN both last one cycle and carry the ack
          state    <= ST_IDLE;
          o_write0 <= 1'b0;
          o_write1 <= 1'b0;
          o_ack    <= 2'b00;
          o_err    <= 1'b0;
          o_busy   <= 1'b0;
          o_nBusEn <= 1'b1;
        end
      endcase
    end
  end

endmodule
